fifo_rd_stream: RTL



---
 rtl/fifo_rd_stream_pkg.sv | 18 +
 rtl/fifo_rd_buf.sv | 66 ++++++
 rtl/fifo_rd_stream.sv | 73 +++++++
 3 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the FIFO read-side stream drain.
// Covers the queue depth, ceil-log2 sizing and mod-3 pointer stepping.
package fifo_rd_stream_pkg;

  localparam int QDEPTH = 3;

  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_rd_buf.sv
// Three-entry register queue with mod-3 pointers, occupancy and synchronous clear.
// Pushes into a full queue and pops from an empty queue are ignored.
module fifo_rd_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [1:0]            occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [QDEPTH];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i && (occ_q != 2'd3);
  assign pop_ok  = pop_i && (occ_q != 2'd0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear_i) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      occ_d    = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is reset so the head word reads as zero out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (!clear_i && push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a FIFO read port (1-cycle read latency) into a valid/ready stream
// through a 3-entry queue, with credit-based read issue and per-burst last flag.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rstn,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            level
);

  localparam int              CNT_W    = clog2_min1(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  logic             inflight_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       occ;
  logic             capture, pop;
  logic             credit_ok;

  // Outstanding reads count against queue space so a returning word always fits.
  assign credit_ok  = ({1'b0, occ} + {2'b0, inflight_q}) < 3'd3;
  assign fifo_rd_en = rd_rstn && !fifo_empty && !flush && credit_ok;

  assign capture = inflight_q && !flush;
  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign level   = occ;
  assign m_last  = m_valid && (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (pop) begin
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      cnt_q      <= cnt_d;
    end
  end

  fifo_rd_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk_i      (rd_clk),
    .rst_n_i    (rd_rstn),
    .clear_i    (flush),
    .push_i     (capture),
    .push_data_i(fifo_dout),
    .pop_i      (pop),
    .head_data_o(m_data),
    .occ_o      (occ)
  );

endmodule
